// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
// The loader is the master; the instruction memory (prgrom) is the slave.
interface uart_prog_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_prog_loader.sv
// UART bootloader: receives an 8N1 byte stream, packs each group of four bytes
// big-endian into a 32-bit instruction and writes it to instruction memory at
// consecutive word addresses, holding the CPU in reset while a load is active.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT   = 2604,
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic                  uart_rx,
    uart_prog_loader_if.master    mem_wr,
    output logic                  loading,
    output logic                  cpu_reset_req,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0]       HALF_BIT    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]       FULL_BIT    = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]       TIMEOUT_END = TW'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH:0] WORDS_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_WORD   = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_e;

    // Receiver state
    logic            rx_meta_q, rx_sync_q;
    rx_state_e       rx_state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q;
    logic            frame_bad_q;

    // Loader state
    ld_state_e             ld_state_q;
    logic [1:0]            byte_idx_q;
    logic [23:0]           partial_q;
    logic [31:0]           wr_data_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH:0]   word_count_q;
    logic [TW-1:0]         timeout_q;
    logic                  got_byte_q;
    logic                  frame_err_q;

    // Two-flop synchroniser for the asynchronous serial line.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; the synchroniser resets to the idle-high line level
    // so that reset release is not mistaken for a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver FSM: mid-bit sampling of start, 8 data bits (LSB first), stop.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_bad_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_bad_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_BIT) begin
                        clk_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        // A line already back high at mid-start-bit was a glitch.
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == FULL_BIT) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == FULL_BIT) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_sync_q) byte_valid_q <= 1'b1;
                        else           frame_bad_q  <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Loader FSM: session control, word packing, write strobe, timeout, full detect.
    always_ff @(posedge clock) begin
        if (reset) begin
            ld_state_q   <= L_IDLE;
            byte_idx_q   <= '0;
            partial_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            timeout_q    <= '0;
            got_byte_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (frame_bad_q) frame_err_q <= 1'b1;

            if (start_load) begin
                // Start or restart: a byte arriving in this same cycle is dropped.
                ld_state_q   <= L_LOAD;
                byte_idx_q   <= '0;
                wr_addr_q    <= '0;
                word_count_q <= '0;
                timeout_q    <= '0;
                got_byte_q   <= 1'b0;
                frame_err_q  <= 1'b0;
            end else begin
                case (ld_state_q)
                    L_IDLE: ;
                    L_LOAD: begin
                        if (wr_en_q) begin
                            // Cycle after the strobe: advance, or stop when memory is full.
                            word_count_q <= word_count_q + 1'b1;
                            if (word_count_q == LAST_WORD) ld_state_q <= L_DONE;
                            else                           wr_addr_q  <= wr_addr_q + 1'b1;
                        end else if (byte_valid_q) begin
                            got_byte_q <= 1'b1;
                            timeout_q  <= '0;
                            byte_idx_q <= byte_idx_q + 1'b1;
                            partial_q  <= {partial_q[15:0], shift_q};
                            if (byte_idx_q == 2'd3) begin
                                wr_data_q <= {partial_q, shift_q};
                                wr_en_q   <= 1'b1;
                            end
                        end else if (got_byte_q) begin
                            // Idle timeout; any partial word is simply abandoned.
                            if (timeout_q == TIMEOUT_END) ld_state_q <= L_DONE;
                            else                          timeout_q  <= timeout_q + 1'b1;
                        end
                    end
                    L_DONE:  ld_state_q <= L_IDLE;
                    default: ld_state_q <= L_IDLE;
                endcase
            end
        end
    end

    assign mem_wr.wr_en   = wr_en_q;
    assign mem_wr.wr_addr = wr_addr_q;
    assign mem_wr.wr_data = wr_data_q;
    assign loading        = (ld_state_q == L_LOAD);
    assign cpu_reset_req  = loading;
    assign load_done      = (ld_state_q == L_DONE);
    assign word_count     = word_count_q;
    assign frame_err      = frame_err_q;

    // WORDS_MAX documents the full-memory word count reached by word_count.
    logic unused_words_max;
    assign unused_words_max = ^WORDS_MAX;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader with small simulation parameters.
// Expected memory contents come from a byte-list model: every four bytes sent
// in a session form one big-endian word at the next address, up to 16 words.
module tb_uart_prog_loader;

    localparam int CPB = 16;
    localparam int TO  = 2000;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_load;
    logic          uart_rx;
    logic          loading, cpu_reset_req, load_done, frame_err;
    logic [AW:0]   word_count;

    uart_prog_loader_if #(.ADDR_WIDTH(AW)) mem_wr ();

    uart_prog_loader #(
        .CLKS_PER_BIT  (CPB),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .start_load   (start_load),
        .uart_rx      (uart_rx),
        .mem_wr       (mem_wr),
        .loading      (loading),
        .cpu_reset_req(cpu_reset_req),
        .load_done    (load_done),
        .word_count   (word_count),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    wr_t        writes[$];
    logic [7:0] sent[$];
    int         done_cnt   = 0;
    int         done_base  = 0;
    int         done_cyc   = 0;
    logic [AW:0] done_wc   = '0;
    logic       done_loading = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the memory write port and load_done pulses.
    always @(negedge clk) begin
        if (mem_wr.wr_en) writes.push_back('{addr: mem_wr.wr_addr, data: mem_wr.wr_data, cyc: cyc});
        if (load_done) begin
            done_cnt     = done_cnt + 1;
            done_cyc     = cyc;
            done_wc      = word_count;
            done_loading = loading;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame plus one idle bit; a bad frame drives the stop bit low
    // across its sampling point and then releases the line.
    task automatic send_byte(input logic [7:0] b, input bit good);
        hold(1'b0, CPB);
        for (int k = 0; k < 8; k++) hold(b[k], CPB);
        if (good) hold(1'b1, CPB);
        else begin
            hold(1'b0, CPB / 2 + 2);
            hold(1'b1, CPB / 2 - 2);
        end
        hold(1'b1, CPB);
        if (good) sent.push_back(b);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    endtask

    task automatic pulse_start();
        sent.delete();
        writes.delete();
        done_base  = done_cnt;
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done_cnt != done_base), 64'd1);
    endtask

    // Reference: words expected from the bytes sent in this session.
    function automatic logic [31:0] ref_word(input int i);
        return {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]};
    endfunction

    task automatic check_writes(input string tag);
        int n_exp = sent.size() / 4;
        if (n_exp > (1 << AW)) n_exp = 1 << AW;
        check({tag, "_nwr"}, 64'(writes.size()), 64'(n_exp));
        for (int i = 0; i < writes.size() && i < n_exp; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(writes[i].addr), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(writes[i].data), 64'(ref_word(i)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start_load = 1'b0;
        uart_rx    = 1'b1;
        repeat (4) @(negedge clk);

        // T1: reset state, then bytes without start_load are ignored.
        check("t1_rst_outputs",
              {60'd0, mem_wr.wr_en, loading, cpu_reset_req, load_done},  64'd0);
        check("t1_rst_addr_data", {28'd0, mem_wr.wr_addr, mem_wr.wr_data}, 64'd0);
        check("t1_rst_wc_ferr", {word_count, frame_err}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        send_random(3);
        check("t1_no_write", 64'(writes.size()), 64'd0);
        check("t1_not_loading", {loading, cpu_reset_req}, 64'd0);
        sent.delete();

        // T2: single word.
        pulse_start();
        check("t2_loading", {loading, cpu_reset_req}, 64'b11);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (4) @(negedge clk);
        check_writes("t2");
        check("t2_data_literal", 64'(writes.size() > 0 ? writes[0].data : 32'h0), 64'h3C01_0010);
        check("t2_wc", 64'(word_count), 64'd1);
        wait_done("t2_done", TO + 200);

        // T3: three words then idle timeout.
        pulse_start();
        send_random(12);
        wait_done("t3_done", TO + 200);
        check_writes("t3");
        check("t3_done_wc", 64'(done_wc), 64'd3);
        check("t3_done_loading", 64'(done_loading), 64'd0);
        if (writes.size() > 0)
            check("t3_timeout_window",
                  64'((done_cyc - writes[writes.size()-1].cyc) >= TO - 10 &&
                      (done_cyc - writes[writes.size()-1].cyc) <= TO + 10), 64'd1);
        @(negedge clk);
        check("t3_wc_held", 64'(word_count), 64'd3);

        // T4: a bad frame sets frame_err and is dropped.
        pulse_start();
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_frame_err", 64'(frame_err), 64'd1);
        check_writes("t4");
        check("t4_word0", 64'(writes.size() > 0 ? writes[0].data : 32'h0), 64'hAABB_CCDD);
        wait_done("t4_done", TO + 200);
        check("t4_frame_err_sticky", 64'(frame_err), 64'd1);

        // T5: partial tail discarded on timeout.
        pulse_start();
        check("t5_frame_err_cleared", 64'(frame_err), 64'd0);
        send_random(7);
        wait_done("t5_done", TO + 200);
        check_writes("t5");
        check("t5_wc", 64'(done_wc), 64'd1);

        // T5b: short low glitches produce no byte.
        pulse_start();
        for (int g = 0; g < 3; g++) begin
            hold(1'b0, 3);
            hold(1'b1, 3 * CPB);
        end
        repeat (200) @(negedge clk);
        check("t5_glitch_nwr", 64'(writes.size()), 64'd0);
        check("t5_glitch_state", {loading, word_count, frame_err}, {1'b1, 5'd0, 1'b0});

        // T6: fill the whole memory.
        pulse_start();
        send_random(64);
        wait_done("t6_done", 200);
        repeat (4) @(negedge clk);
        check_writes("t6");
        check("t6_done_once", 64'(done_cnt - done_base), 64'd1);
        if (writes.size() > 0)
            check("t6_done_after_strobe", 64'(done_cyc - writes[writes.size()-1].cyc), 64'd1);
        check("t6_wc_full", 64'(word_count), 64'd16);
        check("t6_addr_held", 64'(mem_wr.wr_addr), 64'd15);
        check("t6_idle", {loading, cpu_reset_req}, 64'd0);

        // T6b: start_load mid-load restarts the session.
        pulse_start();
        send_random(6);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        check("t6_restart_clear", {loading, mem_wr.wr_addr, word_count}, {1'b1, 4'd0, 5'd0});
        sent.delete();
        writes.delete();
        send_random(4);
        repeat (4) @(negedge clk);
        check_writes("t6_restart");

        // T6c: reset mid-load.
        send_random(5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_reset_clear", {loading, mem_wr.wr_addr, word_count, frame_err},
              {1'b0, 4'd0, 5'd0, 1'b0});
        repeat (3 * CPB) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
